id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus execute-stage operand selection. Latches decoded
//  operands and control at the decode/execute boundary, applies hazard-unit
//  stall/flush, resolves forwarding from MEM/WB, and drives srcA/srcB/aluControl
//  straight into the ALU. Also counts inserted bubbles for hazard profiling.
// PARAMETERS
//  WIDTH  32  datapath width (operands, immediate, forwarded results)
//  REG_W  5   register-specifier width
//  CNT_W  16  bubble-counter width
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  rd1D, rd2D   in   WIDTH  register-file read data (rs, rt) from decode
//  signImmD     in   WIDTH  sign-extended immediate
//  rsD,rtD,rdD  in   REG_W  register specifiers
//  aluControlD  in   3      ALU op code (011 is illegal)
//  aluSrcD      in   1      1: srcB = immediate
//  regDstD      in   1      1: dest = rd, 0: dest = rt
//  regWriteD, memWriteD, memtoRegD  in 1  downstream control bits
//  stallE       in   1      hold all E registers
//  flushE       in   1      load a bubble into E
//  forwardAE    in   2      00 regfile, 01 resultW, 10 aluOutM, 11 regfile
//  forwardBE    in   2      same encoding for operand B
//  aluOutM      in   WIDTH  MEM-stage ALU result
//  resultW      in   WIDTH  WB-stage result
//  srcAE, srcBE out  WIDTH  ALU operands (combinational from E regs + forwards)
//  aluControlE  out  3      ALU op code (never 011)
//  writeDataE   out  WIDTH  forwarded rt value for stores
//  writeRegE    out  REG_W  destination register
//  rsE, rtE     out  REG_W  specifiers back to hazard unit
//  regWriteE, memWriteE, memtoRegE  out 1  registered control
//  illegalOpE   out  1      registered: decode delivered aluControl 011
//  bubbleCount  out  CNT_W  saturating count of flush cycles
// BEHAVIOUR
//  - All E registers update on rising clk; priority reset > flushE > stallE > load.
//  - reset (async): every E register 0 (aluControlE=000, controls 0,
//    writeRegE=0, illegalOpE=0), bubbleCount=0. srcAE/srcBE/writeDataE then
//    follow the 0 registers unless forwarding is selected.
//  - flushE=1: bubble loaded -- regWrite/memWrite/memtoReg/illegalOp=0,
//    aluControl=000, all data/specifier regs=0. flushE overrides stallE.
//  - stallE=1 (flushE=0): all E registers hold; bubbleCount holds.
//  - load: capture all D inputs. aluControlD=011 captured as 000 with
//    illegalOpE=1 and regWriteE=memWriteE=0 (instruction squashed).
//  - Latency: D inputs visible on E outputs one cycle after a load edge.
//  - Forwarding mux is combinational, uses current-cycle aluOutM/resultW:
//    fwdA = forwardAE==10 ? aluOutM : forwardAE==01 ? resultW : rd1E; B alike.
//    Code 11 selects the register value (defined, no X).
//  - srcAE=fwdA; writeDataE=fwdB; srcBE = aluSrcE ? signImmE : fwdB.
//  - writeRegE = regDstE ? rdE : rtE (combinational from E regs).
//  - bubbleCount += 1 on each edge with flushE=1 and reset=0; saturates at
//    2^CNT_W-1, never wraps. Only reset clears it.
//  - Reset asserted mid-stall or mid-flush: immediate clear, no stale hold.
//  - No X propagates to outputs for any defined input combination.
// TESTING
//  1 reset while loaded -> all outputs 0, bubbleCount=0, srcBE=0 with aluSrcE=0.
//  2 load rd1D=5, rd2D=7, aluControlD=010, aluSrcD=0, fwd=00 -> next cycle
//    srcAE=5, srcBE=7, aluControlE=010; aluSrcD=1, signImmD=-4 -> srcBE=FFFFFFFC.
//  3 E holds rd1E=5; forwardAE=10, aluOutM=99 -> srcAE=99; forwardAE=01,
//    resultW=42 -> srcAE=42; forwardAE=11 -> srcAE=5; same for B/writeDataE.
//  4 stallE=1 for 3 cycles with changing D -> E outputs frozen; then
//    stallE=flushE=1 -> bubble loaded, regWriteE=0, bubbleCount+1.
//  5 CNT_W=4, 20 consecutive flushE cycles -> bubbleCount=15 and holds at 15.
//  6 aluControlD=011, regWriteD=1 -> aluControlE=000, illegalOpE=1,
//    regWriteE=0; next legal load clears illegalOpE.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage forwarding muxes and bubble counter.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signImmD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rdD,
  input  logic [2:0]       aluControlD,
  input  logic             aluSrcD,
  input  logic             regDstD,
  input  logic             regWriteD,
  input  logic             memWriteD,
  input  logic             memtoRegD,
  input  logic             stallE,
  input  logic             flushE,
  input  logic [1:0]       forwardAE,
  input  logic [1:0]       forwardBE,
  input  logic [WIDTH-1:0] aluOutM,
  input  logic [WIDTH-1:0] resultW,
  output logic [WIDTH-1:0] srcAE,
  output logic [WIDTH-1:0] srcBE,
  output logic [2:0]       aluControlE,
  output logic [WIDTH-1:0] writeDataE,
  output logic [REG_W-1:0] writeRegE,
  output logic [REG_W-1:0] rsE,
  output logic [REG_W-1:0] rtE,
  output logic             regWriteE,
  output logic             memWriteE,
  output logic             memtoRegE,
  output logic             illegalOpE,
  output logic [CNT_W-1:0] bubbleCount
);

  localparam logic [2:0]       ALU_ILLEGAL = 3'b011;
  localparam logic [CNT_W-1:0] BUBBLE_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [2:0]       alu_ctl;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_write;
    logic             memto_reg;
    logic             illegal_op;
  } e_regs_t;

  e_regs_t          e_q, e_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // Next E contents: flush loads a bubble, stall holds, otherwise capture decode.
  always_comb begin
    e_d      = e_q;
    bubble_d = bubble_q;
    if (flushE) begin
      e_d = '0;
      if (bubble_q != BUBBLE_MAX) begin
        bubble_d = bubble_q + CNT_W'(1);
      end
    end else if (!stallE) begin
      e_d.rd1        = rd1D;
      e_d.rd2        = rd2D;
      e_d.imm        = signImmD;
      e_d.rs         = rsD;
      e_d.rt         = rtD;
      e_d.rd         = rdD;
      e_d.alu_ctl    = aluControlD;
      e_d.alu_src    = aluSrcD;
      e_d.reg_dst    = regDstD;
      e_d.reg_write  = regWriteD;
      e_d.mem_write  = memWriteD;
      e_d.memto_reg  = memtoRegD;
      e_d.illegal_op = 1'b0;
      // Illegal op is squashed: no architectural side effects, flag raised.
      if (aluControlD == ALU_ILLEGAL) begin
        e_d.alu_ctl    = 3'b000;
        e_d.illegal_op = 1'b1;
        e_d.reg_write  = 1'b0;
        e_d.mem_write  = 1'b0;
      end
    end
  end

  // E-stage state and bubble counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q      <= '0;
      bubble_q <= '0;
    end else begin
      e_q      <= e_d;
      bubble_q <= bubble_d;
    end
  end

  // Forwarding muxes use this cycle's MEM/WB results; code 11 falls back to the register.
  always_comb begin
    fwd_a = e_q.rd1;
    fwd_b = e_q.rd2;
    case (forwardAE)
      2'b10:   fwd_a = aluOutM;
      2'b01:   fwd_a = resultW;
      default: fwd_a = e_q.rd1;
    endcase
    case (forwardBE)
      2'b10:   fwd_b = aluOutM;
      2'b01:   fwd_b = resultW;
      default: fwd_b = e_q.rd2;
    endcase
  end

  assign srcAE       = fwd_a;
  assign writeDataE  = fwd_b;
  assign srcBE       = e_q.alu_src ? e_q.imm : fwd_b;
  assign writeRegE   = e_q.reg_dst ? e_q.rd : e_q.rt;
  assign aluControlE = e_q.alu_ctl;
  assign rsE         = e_q.rs;
  assign rtE         = e_q.rt;
  assign regWriteE   = e_q.reg_write;
  assign memWriteE   = e_q.mem_write;
  assign memtoRegE   = e_q.memto_reg;
  assign illegalOpE  = e_q.illegal_op;
  assign bubbleCount = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor compares.
module tb_id_ex_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit          reset;
    bit [31:0]   rd1, rd2, imm, alu_m, res_w;
    bit [4:0]    rs, rt, rd;
    bit [2:0]    op;
    bit          asrc, rdst, rw, mw, m2r, stall, flush;
    bit [1:0]    fa, fb;
  } stim_t;

  typedef struct {
    bit [31:0] src_a, src_b, wdata;
    bit [2:0]  alu_ctl;
    bit [4:0]  wreg, rs, rt;
    bit        rw, mw, m2r, ill;
    int        bub;
  } exp_t;

  // Latched instruction as the execute stage should see it.
  typedef struct {
    bit [31:0] a, b, imm;
    bit [4:0]  rs, rt, rd;
    bit [2:0]  op;
    bit        asrc, rdst, rw, mw, m2r, ill;
  } instr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rd1D, rd2D, signImmD, aluOutM, resultW;
  logic [REG_W-1:0] rsD, rtD, rdD;
  logic [2:0]       aluControlD;
  logic             aluSrcD, regDstD, regWriteD, memWriteD, memtoRegD, stallE, flushE;
  logic [1:0]       forwardAE, forwardBE;
  logic [WIDTH-1:0] srcAE, srcBE, writeDataE;
  logic [2:0]       aluControlE;
  logic [REG_W-1:0] writeRegE, rsE, rtE;
  logic             regWriteE, memWriteE, memtoRegE, illegalOpE;
  logic [CNT_W-1:0] bubbleCount;

  id_ex_stage #(.WIDTH(WIDTH), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rd1D(rd1D), .rd2D(rd2D), .signImmD(signImmD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .aluControlD(aluControlD), .aluSrcD(aluSrcD),
    .regDstD(regDstD), .regWriteD(regWriteD), .memWriteD(memWriteD),
    .memtoRegD(memtoRegD), .stallE(stallE), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .aluOutM(aluOutM), .resultW(resultW),
    .srcAE(srcAE), .srcBE(srcBE), .aluControlE(aluControlE), .writeDataE(writeDataE),
    .writeRegE(writeRegE), .rsE(rsE), .rtE(rtE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .memtoRegE(memtoRegE), .illegalOpE(illegalOpE),
    .bubbleCount(bubbleCount)
  );

  always #5 clk = ~clk;

  stim_t  cur;
  instr_t m;
  int     bubbles = 0;
  exp_t   q[$];
  bit     mon_en = 1'b0;
  int     n_vec = 0;
  int     n_bad = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset = ($urandom_range(0, 39) == 0);
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    s.alu_m = $urandom; s.res_w = $urandom;
    s.rs = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
    s.op = 3'($urandom);
    s.asrc = 1'($urandom); s.rdst = 1'($urandom);
    s.rw = 1'($urandom); s.mw = 1'($urandom); s.m2r = 1'($urandom);
    s.stall = ($urandom_range(0, 3) == 0);
    s.flush = ($urandom_range(0, 5) == 0);
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.reset; rd1D = s.rd1; rd2D = s.rd2; signImmD = s.imm;
    rsD = s.rs; rtD = s.rt; rdD = s.rd; aluControlD = s.op;
    aluSrcD = s.asrc; regDstD = s.rdst; regWriteD = s.rw; memWriteD = s.mw;
    memtoRegD = s.m2r; stallE = s.stall; flushE = s.flush;
    forwardAE = s.fa; forwardBE = s.fb; aluOutM = s.alu_m; resultW = s.res_w;
  endtask

  // What a clock edge does to the stage, stated from the pipeline rules.
  task automatic model_edge(input stim_t s);
    if (s.reset) begin
      m = '{default: '0};
      bubbles = 0;
    end else if (s.flush) begin
      m = '{default: '0};
      bubbles = (bubbles < CNT_MAX) ? bubbles + 1 : CNT_MAX;
    end else if (!s.stall) begin
      m.a = s.rd1; m.b = s.rd2; m.imm = s.imm;
      m.rs = s.rs; m.rt = s.rt; m.rd = s.rd;
      m.asrc = s.asrc; m.rdst = s.rdst; m.m2r = s.m2r;
      m.ill = (s.op == 3'd3);
      m.op  = m.ill ? 3'd0 : s.op;
      m.rw  = s.rw && !m.ill;
      m.mw  = s.mw && !m.ill;
    end
  endtask

  function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] regv,
                                     input stim_t s);
    if (sel == 2'd2) return s.alu_m;
    if (sel == 2'd1) return s.res_w;
    return regv;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    e.src_a   = pick(s.fa, m.a, s);
    e.wdata   = pick(s.fb, m.b, s);
    e.src_b   = m.asrc ? m.imm : e.wdata;
    e.alu_ctl = m.op;
    e.wreg    = m.rdst ? m.rd : m.rt;
    e.rs = m.rs; e.rt = m.rt;
    e.rw = m.rw; e.mw = m.mw; e.m2r = m.m2r; e.ill = m.ill;
    e.bub = bubbles;
    return e;
  endfunction

  // One cycle: settle the edge into the model, present new stimulus, queue the prediction.
  task automatic apply(input stim_t s);
    @(posedge clk);
    model_edge(cur);
    #1;
    cur = s;
    drive(s);
    if (s.reset) begin
      m = '{default: '0};
      bubbles = 0;
    end
    q.push_back(predict(s));
    mon_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the stage presents outputs; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("srcAE", srcAE, e.src_a);
      chk("srcBE", srcBE, e.src_b);
      chk("writeDataE", writeDataE, e.wdata);
      chk("aluControlE", 32'(aluControlE), 32'(e.alu_ctl));
      chk("writeRegE", 32'(writeRegE), 32'(e.wreg));
      chk("rsE", 32'(rsE), 32'(e.rs));
      chk("rtE", 32'(rtE), 32'(e.rt));
      chk("regWriteE", 32'(regWriteE), 32'(e.rw));
      chk("memWriteE", 32'(memWriteE), 32'(e.mw));
      chk("memtoRegE", 32'(memtoRegE), 32'(e.m2r));
      chk("illegalOpE", 32'(illegalOpE), 32'(e.ill));
      chk("bubbleCount", 32'(bubbleCount), 32'(e.bub));
    end else if (mon_en) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty at %0t: got no prediction expected one", $time);
    end
  end

  initial begin
    stim_t s;
    m = '{default: '0};
    cur = idle();
    cur.reset = 1'b1;
    drive(cur);

    // Load something, then reset while loaded.
    s = idle(); s.rd1 = 32'h1234; s.rd2 = 32'h55; s.rw = 1'b1; s.op = 3'd2;
    apply(s);
    apply(idle());
    s = idle(); s.reset = 1'b1;
    apply(s);
    apply(idle());

    // Basic load, then immediate select with -4.
    s = idle(); s.rd1 = 32'd5; s.rd2 = 32'd7; s.op = 3'b010;
    apply(s);
    s.asrc = 1'b1; s.imm = 32'hFFFF_FFFC;
    apply(s);
    // Hold E (rd1=5, rd2=7, imm=-4) and walk the forwarding codes.
    s = idle(); s.stall = 1'b1;
    s.rd1 = 32'd5; s.rd2 = 32'd7; s.imm = 32'hFFFF_FFFC; s.asrc = 1'b1; s.op = 3'b010;
    apply(s);
    for (int i = 0; i < 4; i++) begin
      s.fa = 2'(i); s.fb = 2'(3 - i); s.alu_m = 32'd99; s.res_w = 32'd42;
      s.asrc = 1'b0;
      apply(s);
    end

    // Stall for 3 cycles with changing D, then stall+flush.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.reset = 1'b0; s.stall = 1'b1; s.flush = 1'b0;
      apply(s);
    end
    s.flush = 1'b1;
    apply(s);
    apply(idle());

    // Illegal op squashed, then cleared by a legal load.
    s = idle(); s.op = 3'b011; s.rw = 1'b1; s.mw = 1'b1; s.rd1 = 32'd3;
    apply(s);
    s.op = 3'b110;
    apply(s);
    apply(idle());

    // Saturation: 20 back-to-back flushes, then confirm it holds.
    for (int i = 0; i < 20; i++) begin
      s = rand_stim(); s.reset = 1'b0; s.flush = 1'b1;
      apply(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.reset = 1'b0; s.flush = 1'b0;
      apply(s);
    end

    // Reset asserted in the middle of a flush, then a stall.
    s = rand_stim(); s.flush = 1'b1; s.reset = 1'b1;
    apply(s);
    s = rand_stim(); s.reset = 1'b0; s.flush = 1'b0; s.stall = 1'b0;
    apply(s);
    s.stall = 1'b1;
    apply(s);
    s.reset = 1'b1;
    apply(s);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply(rand_stim());
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover predictions expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
